// File: rtl/prog_loader.sv
// Boot-time program loader: assembles little-endian instruction words from a framed
// UART byte stream, writes them to instruction memory and releases the core once the checksum matches.
module prog_loader #(
    parameter int          ADDR_W = 10,
    parameter logic [7:0]  SYNC   = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              error
);

    // state  | meaning
    // IDLE   | waiting for the first SYNC byte, everything else ignored
    // LEN0   | expecting LEN_LO
    // LEN1   | expecting LEN_HI, length is range-checked here
    // DATA   | collecting payload bytes, one write per 4 bytes
    // CSUM   | expecting the checksum of the payload
    // DONE   | image accepted, core released, input ignored until rst
    // ERR    | frame rejected, core held, waiting for SYNC
    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_t;

    // 17 bits so that a full 16-bit LEN can be compared against 2^ADDR_W
    localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_W;

    state_t      state;
    logic [7:0]  len_lo;
    logic [15:0] words_left;
    logic [7:0]  sum;
    logic [1:0]  byte_cnt;
    logic [23:0] word_buf;
    logic [15:0] len_full;

    assign len_full = {rx_data, len_lo};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            len_lo     <= '0;
            words_left <= '0;
            sum        <= '0;
            byte_cnt   <= '0;
            word_buf   <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_rst    <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            // address advances in the cycle after each write pulse
            if (imem_we) imem_addr <= imem_addr + ADDR_W'(1);

            if (rx_valid) begin
                case (state)
                    S_IDLE: begin
                        if (rx_data == SYNC) begin
                            state     <= S_LEN0;
                            imem_addr <= '0;
                            sum       <= '0;
                            byte_cnt  <= '0;
                        end
                    end
                    S_LEN0: begin
                        len_lo <= rx_data;
                        state  <= S_LEN1;
                    end
                    S_LEN1: begin
                        if ({1'b0, len_full} > MAX_LEN) begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end else if (len_full == 16'd0) begin
                            state <= S_CSUM;
                        end else begin
                            words_left <= len_full;
                            state      <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        sum      <= sum + rx_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: word_buf[7:0]   <= rx_data;
                            2'd1: word_buf[15:8]  <= rx_data;
                            2'd2: word_buf[23:16] <= rx_data;
                            default: begin
                                imem_we    <= 1'b1;
                                imem_wdata <= {rx_data, word_buf};
                                words_left <= words_left - 16'd1;
                                if (words_left == 16'd1) state <= S_CSUM;
                            end
                        endcase
                    end
                    S_CSUM: begin
                        if (rx_data == sum) begin
                            state   <= S_DONE;
                            cpu_rst <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end
                    end
                    S_DONE: begin
                    end
                    S_ERR: begin
                        if (rx_data == SYNC) begin
                            state     <= S_LEN0;
                            error     <= 1'b0;
                            imem_addr <= '0;
                            sum       <= '0;
                            byte_cnt  <= '0;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes are queued by the stimulus,
// a monitor pops and compares each imem_we pulse; status flags are checked inline.
module tb_prog_loader;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_rst;
    logic          done;
    logic          error;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] bq[$];
    int         n_chk = 0;
    int         n_fail = 0;

    prog_loader #(.ADDR_W(AW), .SYNC(8'hA5)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!rst && imem_we) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", imem_addr, imem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(imem_addr), e.addr);
                chk("wr_data", imem_wdata, e.data);
            end
        end
    end

    task automatic send_bq(input int gmax);
        while (bq.size() > 0) begin
            logic [7:0] b;
            b = bq.pop_front();
            rx_valid = 1'b0;
            repeat ((gmax > 0) ? $urandom_range(gmax, 0) : 0) @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = b;
            @(negedge clk);
            rx_valid = 1'b0;
        end
    endtask

    task automatic push_bytes(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        bq.push_back(b0); bq.push_back(b1); bq.push_back(b2); bq.push_back(b3);
    endtask

    task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // nominal 2-word frame; csum selects the checksum byte sent
    task automatic nominal(input logic [7:0] csum, input int gmax);
        expect_wr(0, 32'h0000_0013);
        expect_wr(1, 32'h0010_0093);
        bq.push_back(8'hA5); bq.push_back(8'h02); bq.push_back(8'h00);
        push_bytes(8'h13, 8'h00, 8'h00, 8'h00);
        push_bytes(8'h93, 8'h00, 8'h10, 8'h00);
        bq.push_back(csum);
        send_bq(gmax);
    endtask

    task automatic status(input string tag, input logic d, input logic c, input logic e);
        chk({tag, "_done"},    32'(done),    32'(d));
        chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'(c));
        chk({tag, "_error"},   32'(error),   32'(e));
    endtask

    task automatic reset_state(input string tag);
        chk({tag, "_we"},    32'(imem_we),   32'd0);
        chk({tag, "_addr"},  32'(imem_addr), 32'd0);
        chk({tag, "_wdata"}, imem_wdata,     32'd0);
        status(tag, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rx_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic q_empty(input string tag);
        chk({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset_state("reset");
        rst = 1'b0;

        // nominal, back-to-back bytes
        nominal(8'hB6, 0);
        status("nominal_b2b", 1'b1, 1'b0, 1'b0);
        q_empty("nominal_b2b");

        // nominal with random gaps
        do_reset();
        nominal(8'hB6, 20);
        status("nominal_gaps", 1'b1, 1'b0, 1'b0);
        q_empty("nominal_gaps");

        // bad checksum, then SYNC in the very next cycle
        do_reset();
        nominal(8'hB7, 0);
        status("bad_csum", 1'b0, 1'b1, 1'b1);
        q_empty("bad_csum");
        nominal(8'hB6, 0);
        status("resend", 1'b1, 1'b0, 1'b0);
        q_empty("resend");

        // length overflow (LEN=5 > 4), then boundary LEN=4
        do_reset();
        bq.push_back(8'hA5); bq.push_back(8'h05); bq.push_back(8'h00);
        send_bq(0);
        status("overflow", 1'b0, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        expect_wr(0, 32'h0000_0001);
        expect_wr(1, 32'h0000_0002);
        expect_wr(2, 32'h0000_0003);
        expect_wr(3, 32'h0000_0004);
        bq.push_back(8'hA5); bq.push_back(8'h04); bq.push_back(8'h00);
        push_bytes(8'h01, 8'h00, 8'h00, 8'h00);
        push_bytes(8'h02, 8'h00, 8'h00, 8'h00);
        push_bytes(8'h03, 8'h00, 8'h00, 8'h00);
        push_bytes(8'h04, 8'h00, 8'h00, 8'h00);
        bq.push_back(8'h0A);
        send_bq(2);
        status("max_len", 1'b1, 1'b0, 1'b0);
        q_empty("max_len");

        // preamble noise and zero length
        do_reset();
        bq.push_back(8'h00); bq.push_back(8'hFF); bq.push_back(8'h5A);
        push_bytes(8'hA5, 8'h00, 8'h00, 8'h00);
        send_bq(0);
        status("zero_len", 1'b1, 1'b0, 1'b0);
        q_empty("zero_len");

        // reset after the 6th payload byte
        do_reset();
        expect_wr(0, 32'h0000_0013);
        bq.push_back(8'hA5); bq.push_back(8'h02); bq.push_back(8'h00);
        push_bytes(8'h13, 8'h00, 8'h00, 8'h00);
        bq.push_back(8'h93); bq.push_back(8'h00);
        send_bq(0);
        rst = 1'b1;
        @(negedge clk);
        reset_state("mid_rst");
        rst = 1'b0;
        repeat (10) @(negedge clk);
        q_empty("mid_rst");

        // reset from DONE
        nominal(8'hB6, 0);
        status("pre_done_rst", 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        status("done_rst", 1'b0, 1'b1, 1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        q_empty("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader for the single-cycle RISC-V core. It receives a framed byte stream from the UART receiver and assembles little-endian 32-bit instruction words. It writes those words sequentially into the instruction memory's write port and holds the core in reset until a complete, checksum-verified image has been stored. It sits upstream of the core's instruction ROM and drives the core's reset.

## Interface

Parameters:

- ADDR_W, 10, instruction-memory word-address width; capacity 2^ADDR_W words
- SYNC, 8'hA5, frame start byte

Ports:

- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- rx_valid  input  1  one-cycle strobe: rx_data holds a received byte
- rx_data  input  8  received byte
- imem_we  output  1  instruction-memory write enable, one-cycle pulse per word
- imem_addr  output  ADDR_W  word address of the write
- imem_wdata  output  32  instruction word to write
- cpu_rst  output  1  core reset, high until the image is accepted
- done  output  1  image loaded and verified; sticky until rst
- error  output  1  frame rejected; cleared by a new SYNC byte or by rst

## Operation

- Frame format: SYNC, LEN_LO, LEN_HI, then 4*LEN payload bytes, then CSUM. LEN is a 16-bit word count. CSUM is the 8-bit sum (mod 256) of payload bytes only.
- State machine:
  - IDLE: non-SYNC bytes are ignored. SYNC goes to LEN0.
  - LEN0: capture LEN_LO, go to LEN1.
  - LEN1: capture LEN_HI.
    - If LEN > 2^ADDR_W, go to ERR.
    - If LEN == 0, go to CSUM.
    - Otherwise go to DATA.
  - DATA: a 2-bit byte counter places each byte into word bits [8k+7:8k], k=0..3, first byte least significant. The running sum adds every payload byte. On the 4th byte, issue a write and advance the word address. After word LEN-1 is written, go to CSUM.
  - CSUM: compare the byte with the running sum. Match goes to DONE; mismatch goes to ERR.
  - DONE: cpu_rst=0, done=1. All further bytes are ignored until rst.
  - ERR: error=1, cpu_rst=1. SYNC clears error, zeroes the address, sum and byte counter, and goes to LEN0. Other bytes are ignored.
- Entry into LEN0 always zeroes the address, sum and byte counter.
- Words already written before an error remain in memory. The core stays in reset, so they are harmless.
- Word address width is ADDR_W. LEN == 2^ADDR_W is legal: the last write lands at address 2^ADDR_W-1 and the address counter is not used afterward. No address wrap can occur inside a legal frame.
- Only accepted bytes (rx_valid=1) advance state. Gaps of any length between bytes are allowed; there is no timeout.

## Timing

- Reset values:
  - state=IDLE, imem_we=0, imem_addr=0, imem_wdata=0
  - cpu_rst=1, done=0, error=0
  - sum=0, byte counter=0
- All outputs are registered.
- imem_we is high for exactly the one cycle following the clock edge that accepted byte 3 of a word. imem_addr and imem_wdata are valid in that same cycle. imem_addr increments in the cycle after the pulse.
- cpu_rst falls, and done rises, on the edge that accepts a matching CSUM byte. The core therefore runs its first instruction no earlier than the next cycle.
- error rises on the edge accepting the offending LEN_HI or CSUM byte.
- Back-to-back rx_valid (every cycle) must be sustained without loss. This includes a SYNC arriving in the cycle immediately after an ERR transition.
- rst mid-frame returns everything to reset values on the next edge. Partial words are discarded. cpu_rst is reasserted even from DONE.

## Test plan

- Nominal 2-word load:
  - Stimulus: A5 02 00, then 13 00 00 00, then 93 00 10 00, then CSUM=0xB6.
  - Writes: addr 0 data 0x00000013, then addr 1 data 0x00100093.
  - Then done=1, cpu_rst=0, error=0.
- Bad checksum:
  - Stimulus: same frame with CSUM=0xB7.
  - Both writes occur, then error=1, cpu_rst=1, done=0.
  - A new A5 clears error and the resent correct frame finishes with done=1.
- Length overflow:
  - Stimulus: ADDR_W=2, frame A5 05 00.
  - error=1 right after LEN_HI, no imem_we pulses.
  - A following legal frame with LEN=4 writes addresses 0..3 and sets done=1.
- Zero length and preamble noise:
  - Stimulus: bytes 00 FF 5A, then A5 00 00 00.
  - Noise bytes are ignored, no writes occur, done=1.
- Throughput and gaps:
  - Send the nominal frame with rx_valid held high every cycle, then again after rst with random 0-20 cycle gaps.
  - Write sequence and final state are identical in both cases.
- Reset mid-operation:
  - Assert rst after the 6th payload byte: all outputs return to reset values and the partial word is never written.
  - Assert rst in DONE: cpu_rst returns to 1 and done to 0.
